// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the memory word and the cache/RAM arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that serialises icache reads and dcache reads/writes onto
// one RAM port, with a per-access timeout that raises a sticky memerr.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready,
  output logic  memerr
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  arb_state_t    state;
  logic          last_d;
  logic          memerr_q;
  logic [CW-1:0] cnt;
  word_t         lat_addr;
  word_t         lat_store;
  logic          lat_wen;

  logic i_req, d_req, grant_d, grant_i;
  logic busy, timeout, done;

  assign i_req   = iREN;
  assign d_req   = dREN | dWEN;
  // On a tie, the side that was not served last wins.
  assign grant_d = d_req & (~i_req | ~last_d);
  assign grant_i = i_req & ~grant_d;

  assign busy    = (state != IDLE);
  // The final permitted BUSY cycle without ramready closes the access as an abort.
  assign timeout = busy & ~ramready & (cnt == LIMIT);
  assign done    = busy & (ramready | timeout);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      memerr_q  <= 1'b0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DBUSY;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wen   <= dWEN;
            cnt       <= '0;
          end else if (grant_i) begin
            state     <= IBUSY;
            lat_addr  <= iaddr;
            lat_store <= '0;
            lat_wen   <= 1'b0;
            cnt       <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (done) begin
            state  <= IDLE;
            last_d <= (state == DBUSY);
            if (timeout) memerr_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = busy & ~lat_wen;
    ramWEN   = busy & lat_wen;
    ramaddr  = busy ? lat_addr : '0;
    ramstore = busy ? lat_store : '0;

    iwait = iREN & ~((state == IBUSY) & done);
    dwait = d_req & ~((state == DBUSY) & done);
    iload = ((state == IBUSY) && ramready) ? ramload : '0;
    dload = ((state == DBUSY) && ramready) ? ramload : '0;

    memerr = memerr_q;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 255, cycles a granted RAM access may take before it is aborted.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  single clock, all state on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM access complete, one-cycle pulse.
- memerr  out  1  sticky timeout flag.
REQ-003 SHALL use one clock and a synchronous, active-low reset; the ports are named CLK and nRST.

Function
REQ-004 SHALL implement FSM states IDLE, IBUSY and DBUSY.
REQ-005 IDLE with exactly one requester pending SHALL move to that requester's BUSY state on the next edge.
REQ-006 IDLE with both requesters pending SHALL grant the requester not served last, tracked in a last_d flag (round-robin).
REQ-007 A dcache request SHALL be dREN or dWEN; if both are high, SHALL be treated as a write.
REQ-008 On grant, SHALL latch the address, write data and direction into registers; RAM outputs SHALL be driven only from these latched values, so later requester changes have no effect.
REQ-009 In IBUSY/DBUSY SHALL hold ramREN or ramWEN (never both) high together with the latched ramaddr and ramstore.
REQ-010 In IDLE SHALL drive ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-011 iwait SHALL be 1 whenever iREN=1, except in the IBUSY cycle where ramready=1; in that cycle iload=ramload. Same rule for dwait/dload with DBUSY.
REQ-012 When no request is pending, iwait=dwait=0; iload=dload=0 except in the completion cycle.
REQ-013 On ramready in a BUSY state SHALL return to IDLE and update last_d (1 after DBUSY, 0 after IBUSY).
REQ-014 Latency SHALL be 1 grant cycle plus the RAM latency; there SHALL be one IDLE bubble between back-to-back transactions.
REQ-015 ramready seen in IDLE SHALL be ignored.
REQ-016 A BUSY cycle counter SHALL clear on grant and increment each BUSY cycle without ramready.
REQ-017 When the counter reaches MAX_WAIT, SHALL return to IDLE, complete the requester that cycle (wait=0, load=0) and set memerr.
REQ-018 memerr SHALL clear only on reset.
REQ-019 A requester that drops its request mid-BUSY SHALL NOT abort the transaction; the RAM access completes and the result is discarded.

Reset
REQ-020 While nRST=0 at an edge, SHALL set: state=IDLE, last_d=0 (dcache wins the first tie), counter=0, memerr=0 and latched registers=0.
REQ-021 Reset asserted during BUSY SHALL abandon the access; RAM strobes SHALL be low from the next cycle.

Structure
REQ-022 The state enum (arb_state_t) and the word_t type SHALL live in cpu_types_pkg; MAX_WAIT stays a module parameter.
REQ-023 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- iREN only, iaddr=0x40, RAM returns 0x1234 after 3 cycles -> ramREN for 3 cycles at 0x40; iwait low exactly in the ramready cycle with iload=0x1234.
- iREN and dWEN in the same cycle after reset, daddr=0x80, dstore=0xDEAD -> DBUSY first with ramWEN, ramstore=0xDEAD; IBUSY next after one IDLE bubble.
- Continuous contention over 4 transactions -> grants alternate D, I, D, I.
- daddr changed from 0x80 to 0x84 mid-DBUSY -> ramaddr stays 0x80.
- MAX_WAIT=4 and ramready never asserted -> abort after 4 BUSY cycles with dwait=0, dload=0; memerr=1 and held until nRST.
- nRST low during IBUSY -> next cycle ramREN=0, state IDLE, memerr=0.
